// File: rtl/digdug_devbus_arbiter_if.sv
// Device-bus sharing interface between the three game CPUs and the I/O device module.
// The master view belongs to the arbiter; the slave view is the CPU/device side.
interface digdug_devbus_arbiter_if;
    logic        pause;
    logic [2:0]  req;
    logic [2:0]  rq_wr;
    logic [47:0] rq_ad;
    logic [23:0] rq_di;
    logic [2:0]  ack;
    logic [7:0]  rq_do;
    logic [15:0] dev_ad;
    logic        dev_rd;
    logic        dev_wr;
    logic [7:0]  dev_di;
    logic [7:0]  dev_do;
    logic        dev_dv;
    logic [1:0]  gnt_id;
    logic        tout;

    modport master (
        input  pause, req, rq_wr, rq_ad, rq_di, dev_do, dev_dv,
        output ack, rq_do, dev_ad, dev_rd, dev_wr, dev_di, gnt_id, tout
    );

    modport slave (
        output pause, req, rq_wr, rq_ad, rq_di, dev_do, dev_dv,
        input  ack, rq_do, dev_ad, dev_rd, dev_wr, dev_di, gnt_id, tout
    );
endinterface

// File: rtl/digdug_devbus_arbiter.sv
// Device-bus arbiter: grants the shared I/O bus to the main, sub or sound CPU,
// runs one read or write at a time and forces completion of reads that never see DEV_DV.
// All outputs are registered; the next-state logic computes their next values.
module digdug_devbus_arbiter #(
    parameter int TIMEOUT    = 16,
    parameter bit FIXED_PRIO = 1'b0
) (
    input logic MCLK,
    input logic RESET,
    digdug_devbus_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        WAITDV = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_r, state_s;
    logic [1:0]  id_r, id_s;
    logic        wr_r, wr_s;
    logic [7:0]  cnt_r, cnt_s;
    logic [1:0]  last_r, last_s;
    logic [1:0]  gnt_id_r, gnt_id_s;
    logic [2:0]  ack_r, ack_s;
    logic [7:0]  rq_do_r, rq_do_s;
    logic        tout_r, tout_s;
    logic [15:0] dev_ad_r, dev_ad_s;
    logic [7:0]  dev_di_r, dev_di_s;
    logic        dev_rd_r, dev_rd_s;
    logic        dev_wr_r, dev_wr_s;
    logic [1:0]  pick_s;

    // First pending requester after the last one served, wrapping 0..2.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] cand;
        logic [1:0] pick;
        logic       found;
        cand  = last;
        pick  = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Lowest-numbered pending requester.
    function automatic logic [1:0] fixed_pick(input logic [2:0] req);
        logic [1:0] pick;
        if (req[0]) begin
            pick = 2'd0;
        end else if (req[1]) begin
            pick = 2'd1;
        end else begin
            pick = 2'd2;
        end
        return pick;
    endfunction

    function automatic logic [15:0] ad_slice(input logic [47:0] ad, input logic [1:0] id);
        case (id)
            2'd0:    return ad[15:0];
            2'd1:    return ad[31:16];
            default: return ad[47:32];
        endcase
    endfunction

    function automatic logic [7:0] di_slice(input logic [23:0] di, input logic [1:0] id);
        case (id)
            2'd0:    return di[7:0];
            2'd1:    return di[15:8];
            default: return di[23:16];
        endcase
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] id);
        case (id)
            2'd0:    return 3'b001;
            2'd1:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    // Arbitration winner among the currently pending requests.
    always_comb begin
        if (FIXED_PRIO) begin
            pick_s = fixed_pick(bus.req);
        end else begin
            pick_s = rr_pick(bus.req, last_r);
        end
    end

    // Next state and next register/output values; strobes and ACK default low.
    always_comb begin
        state_s  = state_r;
        id_s     = id_r;
        wr_s     = wr_r;
        cnt_s    = cnt_r;
        last_s   = last_r;
        gnt_id_s = gnt_id_r;
        ack_s    = 3'b000;
        rq_do_s  = rq_do_r;
        tout_s   = tout_r;
        dev_ad_s = dev_ad_r;
        dev_di_s = dev_di_r;
        dev_rd_s = 1'b0;
        dev_wr_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!bus.pause && (bus.req != 3'b000)) begin
                    id_s     = pick_s;
                    wr_s     = bus.rq_wr[pick_s];
                    gnt_id_s = pick_s;
                    dev_ad_s = ad_slice(bus.rq_ad, pick_s);
                    dev_di_s = di_slice(bus.rq_di, pick_s);
                    dev_wr_s = bus.rq_wr[pick_s];
                    dev_rd_s = ~bus.rq_wr[pick_s];
                    state_s  = ADDR;
                end else begin
                    state_s  = IDLE;
                end
            end
            ADDR: begin
                cnt_s = 8'd0;
                if (wr_r) begin
                    ack_s   = onehot(id_r);
                    state_s = DONE;
                end else if (bus.dev_dv) begin
                    rq_do_s = bus.dev_do;
                    ack_s   = onehot(id_r);
                    state_s = DONE;
                end else begin
                    dev_rd_s = 1'b1;
                    state_s  = WAITDV;
                end
            end
            WAITDV: begin
                if (bus.dev_dv) begin
                    rq_do_s = bus.dev_do;
                    ack_s   = onehot(id_r);
                    state_s = DONE;
                end else if (cnt_r == CNT_LAST) begin
                    rq_do_s = 8'hFF;
                    tout_s  = 1'b1;
                    ack_s   = onehot(id_r);
                    state_s = DONE;
                end else begin
                    cnt_s    = cnt_r + 8'd1;
                    dev_rd_s = 1'b1;
                    state_s  = WAITDV;
                end
            end
            DONE: begin
                last_s  = id_r;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; RESET aborts any transaction without an ACK.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            state_r  <= IDLE;
            id_r     <= 2'd0;
            wr_r     <= 1'b0;
            cnt_r    <= 8'd0;
            last_r   <= 2'd2;
            gnt_id_r <= 2'd0;
            ack_r    <= 3'b000;
            rq_do_r  <= 8'h00;
            tout_r   <= 1'b0;
            dev_ad_r <= 16'h0000;
            dev_di_r <= 8'h00;
            dev_rd_r <= 1'b0;
            dev_wr_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            id_r     <= id_s;
            wr_r     <= wr_s;
            cnt_r    <= cnt_s;
            last_r   <= last_s;
            gnt_id_r <= gnt_id_s;
            ack_r    <= ack_s;
            rq_do_r  <= rq_do_s;
            tout_r   <= tout_s;
            dev_ad_r <= dev_ad_s;
            dev_di_r <= dev_di_s;
            dev_rd_r <= dev_rd_s;
            dev_wr_r <= dev_wr_s;
        end
    end

    assign bus.ack    = ack_r;
    assign bus.rq_do  = rq_do_r;
    assign bus.dev_ad = dev_ad_r;
    assign bus.dev_rd = dev_rd_r;
    assign bus.dev_wr = dev_wr_r;
    assign bus.dev_di = dev_di_r;
    assign bus.gnt_id = gnt_id_r;
    assign bus.tout   = tout_r;

endmodule
